// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BITS_CONV = 14;
  localparam int unsigned VALOR_MAX = 9999;

  typedef enum logic [1:0] {
    Idle,
    Carga,
    Desloca,
    Fim
  } estado_t;

  typedef struct packed {
    logic [3:0] milhar;
    logic [3:0] centena;
    logic [3:0] dezena;
    logic [3:0] unidade;
  } bcd_t;

endpackage

// File: rtl/bcd_passo_dabble.sv
// One double-dabble step: add 3 to every digit >= 5, then shift the four digits left
// taking bit_novo in at the bottom.
module bcd_passo_dabble
  import bcd_pkg::*;
(
  input  bcd_t entrada,
  input  logic bit_novo,
  output bcd_t saida
);

  function automatic logic [3:0] ajusta(input logic [3:0] d);
    return (d >= 4'd5) ? d + 4'd3 : d;
  endfunction

  // Accumulators never exceed 9999, so the bit shifted out of milhar is always 0.
  always_comb begin
    saida = bcd_t'(16'({ajusta(entrada.milhar), ajusta(entrada.centena),
                        ajusta(entrada.dezena), ajusta(entrada.unidade), bit_novo}));
  end

endmodule

// File: rtl/bcd_conversor_sequencial.sv
// Two-requester round-robin front end feeding one iterative binary-to-BCD converter
// (sign + four digits, saturating at VALOR_MAX).
module bcd_conversor_sequencial #(
  parameter int unsigned LARGURA   = 32,
  parameter int unsigned BITS_CONV = bcd_pkg::BITS_CONV,
  parameter int unsigned VALOR_MAX = bcd_pkg::VALOR_MAX
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         req,
  input  logic [LARGURA-1:0] valor0,
  input  logic [LARGURA-1:0] valor1,
  output logic [1:0]         ack,
  output logic               ocupado,
  output logic               done,
  output logic               dono,
  output logic               sinal,
  output logic [3:0]         milhar,
  output logic [3:0]         centena,
  output logic [3:0]         dezena,
  output logic [3:0]         unidade,
  output logic               overflow
);
  import bcd_pkg::*;

  localparam int unsigned LargCnt = $clog2(BITS_CONV);

  estado_t              estado;
  logic [LARGURA-1:0]   valor_q;
  logic [LARGURA-1:0]   magnitude;
  logic                 vencedor;
  logic                 vencedor_q;
  logic                 ptr_q;
  logic                 sinal_q;
  logic                 sat_q;
  logic [BITS_CONV-1:0] src_q;
  logic [LargCnt-1:0]   cnt_q;
  bcd_t                 acc_q;
  bcd_t                 passo;

  // Contention goes to ptr_q, which always names the requester not granted last.
  always_comb begin
    vencedor = (req == 2'b11) ? ptr_q : req[1];
  end

  always_comb begin
    magnitude = valor_q[LARGURA-1] ? (~valor_q + LARGURA'(1)) : valor_q;
  end

  assign ocupado = (estado != Idle);

  bcd_passo_dabble u_passo (
    .entrada  (acc_q),
    .bit_novo (src_q[BITS_CONV-1]),
    .saida    (passo)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      estado     <= Idle;
      valor_q    <= '0;
      vencedor_q <= 1'b0;
      ptr_q      <= 1'b0;
      sinal_q    <= 1'b0;
      sat_q      <= 1'b0;
      src_q      <= '0;
      cnt_q      <= '0;
      acc_q      <= '0;
      ack        <= 2'b00;
      done       <= 1'b0;
      dono       <= 1'b0;
      sinal      <= 1'b0;
      overflow   <= 1'b0;
      milhar     <= 4'd0;
      centena    <= 4'd0;
      dezena     <= 4'd0;
      unidade    <= 4'd0;
    end else begin
      unique case (estado)
        Idle: begin
          if (req != 2'b00) begin
            valor_q    <= vencedor ? valor1 : valor0;
            vencedor_q <= vencedor;
            ptr_q      <= ~vencedor;
            ack        <= vencedor ? 2'b10 : 2'b01;
            estado     <= Carga;
          end
        end
        Carga: begin
          ack     <= 2'b00;
          sinal_q <= valor_q[LARGURA-1];
          if (magnitude > LARGURA'(VALOR_MAX)) begin
            sat_q <= 1'b1;
            src_q <= BITS_CONV'(VALOR_MAX);
          end else begin
            sat_q <= 1'b0;
            src_q <= magnitude[BITS_CONV-1:0];
          end
          acc_q  <= '0;
          cnt_q  <= LargCnt'(BITS_CONV - 1);
          estado <= Desloca;
        end
        Desloca: begin
          acc_q <= passo;
          src_q <= src_q << 1;
          if (cnt_q == '0) begin
            // Last step: publish the step result directly so done and digits rise together.
            milhar   <= passo.milhar;
            centena  <= passo.centena;
            dezena   <= passo.dezena;
            unidade  <= passo.unidade;
            sinal    <= sinal_q;
            overflow <= sat_q;
            dono     <= vencedor_q;
            done     <= 1'b1;
            estado   <= Fim;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        Fim: begin
          done   <= 1'b0;
          estado <= Idle;
        end
        default: estado <= Idle;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_conversor_sequencial.sv
// Directed self-checking bench for bcd_conversor_sequencial.
module tb_bcd_conversor_sequencial;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  req;
  logic [31:0] valor0;
  logic [31:0] valor1;
  logic [1:0]  ack;
  logic        ocupado;
  logic        done;
  logic        dono;
  logic        sinal;
  logic [3:0]  milhar;
  logic [3:0]  centena;
  logic [3:0]  dezena;
  logic [3:0]  unidade;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int ciclo  = 0;

  bcd_conversor_sequencial dut (
    .clock    (clock),
    .reset    (reset),
    .req      (req),
    .valor0   (valor0),
    .valor1   (valor1),
    .ack      (ack),
    .ocupado  (ocupado),
    .done     (done),
    .dono     (dono),
    .sinal    (sinal),
    .milhar   (milhar),
    .centena  (centena),
    .dezena   (dezena),
    .unidade  (unidade),
    .overflow (overflow)
  );

  always #5 clock = ~clock;
  always @(posedge clock) ciclo <= ciclo + 1;

  task automatic verifica(input string tag, input logic [31:0] obs, input logic [31:0] esp);
    checks++;
    if (obs !== esp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, esp);
    end
  endtask

  task automatic espera_ack(output int n);
    n = 0;
    while (ack == 2'b00 && n < 40) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic espera_done(inout int n);
    while (!done && n < 60) begin
      @(negedge clock);
      n++;
    end
  endtask

  task automatic executa(input string tag, input logic [1:0] r, input logic [31:0] v0,
                         input logic [31:0] v1, input logic [1:0] exp_ack,
                         input logic [15:0] exp_dig, input logic exp_sinal,
                         input logic exp_ovf, input logic exp_dono);
    int n;
    @(negedge clock);
    req    = r;
    valor0 = v0;
    valor1 = v1;
    espera_ack(n);
    verifica({tag, "_ack"}, ack, exp_ack);
    verifica({tag, "_lat_ack"}, n, 1);
    req = req & ~ack;
    espera_done(n);
    verifica({tag, "_lat_done"}, n, 16);
    verifica({tag, "_digitos"}, {milhar, centena, dezena, unidade}, exp_dig);
    verifica({tag, "_sinal"}, sinal, exp_sinal);
    verifica({tag, "_overflow"}, overflow, exp_ovf);
    verifica({tag, "_dono"}, dono, exp_dono);
  endtask

  initial begin
    int n;
    int t_ack;
    int ack0_visto;

    reset  = 1'b1;
    req    = 2'b00;
    valor0 = '0;
    valor1 = '0;
    repeat (2) @(negedge clock);
    verifica("rst_digitos", {milhar, centena, dezena, unidade}, 16'h0000);
    verifica("rst_flags", {ack, ocupado, done, dono, sinal, overflow}, 7'b0);
    reset = 1'b0;

    executa("pos1234", 2'b01, 32'd1234, 32'd0, 2'b01, 16'h1234, 1'b0, 1'b0, 1'b0);
    executa("neg507", 2'b10, 32'd0, 32'hFFFF_FE05, 2'b10, 16'h0507, 1'b1, 1'b0, 1'b1);

    // Both requesting continuously: grants alternate, 17 cycles apart.
    @(negedge clock);
    req    = 2'b11;
    valor0 = 32'd11;
    valor1 = 32'd22;
    t_ack  = 0;
    for (int k = 0; k < 4; k++) begin
      espera_ack(n);
      verifica("rr_ack", ack, (k % 2 == 1) ? 2'b10 : 2'b01);
      if (k > 0) verifica("rr_intervalo", ciclo - t_ack, 17);
      t_ack = ciclo;
      if (k == 3) req = 2'b00;
      n = 0;
      espera_done(n);
      verifica("rr_digitos", {milhar, centena, dezena, unidade},
               (k % 2 == 1) ? 16'h0022 : 16'h0011);
      verifica("rr_dono", dono, k % 2);
    end

    executa("sat10000", 2'b01, 32'd10000, 32'd0, 2'b01, 16'h9999, 1'b0, 1'b1, 1'b0);
    executa("max9999", 2'b01, 32'd9999, 32'd0, 2'b01, 16'h9999, 1'b0, 1'b0, 1'b0);
    executa("minint", 2'b01, 32'h8000_0000, 32'd0, 2'b01, 16'h9999, 1'b1, 1'b1, 1'b0);

    // Asynchronous reset in the 8th shift cycle of a new conversion.
    @(negedge clock);
    req    = 2'b01;
    valor0 = 32'd1234;
    espera_ack(n);
    req = 2'b00;
    repeat (8) @(negedge clock);
    verifica("pre_rst_ocupado", ocupado, 1'b1);
    verifica("pre_rst_retido", {sinal, overflow, milhar, centena, dezena, unidade},
             {2'b11, 16'h9999});
    #1 reset = 1'b1;
    #1;
    verifica("rst_async_digitos", {milhar, centena, dezena, unidade}, 16'h0000);
    verifica("rst_async_flags", {ack, ocupado, done, dono, sinal, overflow}, 7'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      verifica("rst_sem_done", done, 1'b0);
    end
    reset = 1'b0;
    executa("pos42", 2'b01, 32'd42, 32'd0, 2'b01, 16'h0042, 1'b0, 1'b0, 1'b0);

    // req[0] raised and dropped while requester 1 is being served.
    @(negedge clock);
    req    = 2'b10;
    valor1 = 32'd5;
    espera_ack(n);
    verifica("drop_ack1", ack, 2'b10);
    ack0_visto = 0;
    @(negedge clock);
    req    = 2'b01;
    valor0 = 32'd7;
    repeat (5) begin
      @(negedge clock);
      if (ack[0]) ack0_visto++;
    end
    req = 2'b00;
    n   = 0;
    while (!done && n < 60) begin
      @(negedge clock);
      if (ack[0]) ack0_visto++;
      n++;
    end
    verifica("drop_digitos", {milhar, centena, dezena, unidade}, 16'h0005);
    verifica("drop_dono", dono, 1'b1);
    repeat (3) begin
      @(negedge clock);
      if (ack[0]) ack0_visto++;
    end
    verifica("drop_sem_ack0", ack0_visto, 0);
    verifica("drop_ocioso", ocupado, 1'b0);

    executa("zero", 2'b01, 32'd0, 32'd0, 2'b01, 16'h0000, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_conversor_sequencial.md
Name: bcd_conversor_sequencial

Overview:
- Multi-cycle binary-to-BCD converter with a round-robin arbiter, so two requesters share one display conversion resource.
- Requester 0 is the CPU output port; requester 1 is the debug/monitor path.
- Each accepted request captures a 32-bit two's-complement value and converts its magnitude with iterative double-dabble, one bit per clock.
- Results are a sign bit and four BCD digits held stable for the 7-segment decoders, plus completion and overflow flags.

Parameters:
- LARGURA, 32, width of each input value (two's complement).
- BITS_CONV, 14, magnitude bits shifted through double-dabble (2^14 > 9999).
- VALOR_MAX, 9999, largest magnitude shown; larger magnitudes saturate.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- req  input  2  req[i] high = requester i wants a conversion; held until ack[i].
- valor0  input  LARGURA  value from requester 0; must be stable while req[0] high.
- valor1  input  LARGURA  value from requester 1; must be stable while req[1] high.
- ack  output  2  one-cycle pulse granting and accepting requester i.
- ocupado  output  1  high whenever FSM is not IDLE.
- done  output  1  one-cycle pulse; result outputs updated this cycle.
- dono  output  1  index of requester owning the current/last result.
- sinal  output  1  1 = captured value was negative.
- milhar, centena, dezena, unidade  output  4 each  BCD digits, each 0..9.
- overflow  output  1  1 = magnitude exceeded VALOR_MAX; digits show 9999.

Behaviour:
- Reset values:
  - All outputs 0, FSM in IDLE.
  - Round-robin pointer favours requester 0.
  - Reset mid-conversion aborts it; no done or ack is issued and held results clear to 0.
- FSM states: IDLE, CARGA, DESLOCA, FIM.
- IDLE:
  - At a rising edge with req != 0, select the winner and capture its value into an internal register; go to CARGA.
  - Arbitration:
    - If only one req is high, that requester wins.
    - If both are high, the one not granted last wins; dono is updated only in FIM, and the pointer updates at grant.
- CARGA (1 cycle):
  - ack[winner] = 1.
  - Compute magnitude = value if value[31] = 0, else (~value + 1), at full 32-bit width.
  - Latch the sign.
  - If magnitude > VALOR_MAX, set the internal saturation flag and load 9999 as the shift source; otherwise load magnitude[BITS_CONV-1:0].
  - Clear the digit accumulators and set the bit counter to BITS_CONV-1; go to DESLOCA.
- DESLOCA (BITS_CONV cycles):
  - Each cycle, add 3 to every digit that is >= 5, then shift {milhar, centena, dezena, unidade, src} left by 1, MSB of the source first.
  - When the counter reaches 0, go to FIM; otherwise decrement.
- FIM (1 cycle):
  - Copy the accumulators to the digit outputs and update sinal, overflow and dono.
  - done = 1; go to IDLE.
  - Outputs hold until the next FIM or reset.
- Latency: req high at edge 0 → ack in cycle 1 → done in cycle BITS_CONV+2 (16 with defaults).
  - Throughput: one conversion per BITS_CONV+3 cycles under back-to-back requests, since IDLE is always visited for one cycle.
- Requests are ignored outside IDLE; req may rise at any time.
  - A req dropped before its grant is simply not served.
  - ack is never issued to a requester whose req was low at the IDLE sampling edge.
- Boundary values:
  - -2^31: magnitude is 2^31 (no wrap because the unsigned 32-bit compare is used), so overflow = 1, sinal = 1, digits 9999.
  - Value 0: sinal = 0, digits 0000.
  - Negative zero does not exist.
- No conversion outputs a digit above 9, by construction.

Decomposition:
- Package bcd_pkg holds:
  - the state enum (IDLE, CARGA, DESLOCA, FIM);
  - the constants VALOR_MAX and BITS_CONV;
  - a 4-digit BCD bundle type.
- Sub-module bcd_passo_dabble: combinational, one add-3/shift step over four digits plus an incoming bit. It is instantiated once and fed by the registered accumulators.
- The arbiter is a few lines inside the top block; no separate module.

Test Plan:
- req=01, valor0=1234 → ack=01 in cycle 1; done in cycle 16; digits 1,2,3,4; sinal=0; overflow=0; dono=0.
- req=10, valor1=-507 (0xFFFFFE05) → digits 0,5,0,7; sinal=1; overflow=0; dono=1.
- req=11 held continuously with valor0=11, valor1=22 → grants alternate 0,1,0,1; done outputs alternate 0011 / 0022; one IDLE cycle between grants.
- valor0=10000, then 0x80000000 → both give overflow=1 and digits 9999; sinal 0 then 1. Then valor0=9999 → overflow=0, digits 9999.
- Reset asserted asynchronously in the 8th DESLOCA cycle → all outputs 0 immediately and no done pulse. After release, a new req with value 42 converts normally to 0042.
- req[0] dropped while busy serving requester 1 → no ack[0] issued; valor0=0 request later gives 0000, sinal=0.
